// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Turns the raw PS/2 Set-2 byte stream into single key events (code, extended
// flag, release flag), optionally drops typematic repeats, and queues events
// in a first-word-fall-through FIFO for the downstream consumer.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   byte_in, byte_valid   received scan-code byte and its one-cycle strobe
//   ev_rd                 pop the head event (ignored while empty)
//   ev_code/ev_ext/ev_release  head event fields (stale while empty)
//   ev_empty, ev_full     FIFO status
//   overflow              sticky: an event was dropped because the FIFO was full
module ps2_scancode_decoder #(
  parameter int DEPTH           = 8,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       ev_rd,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       ev_empty,
  output logic       ev_full,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                                                 is_discard = 1'b0;
    endcase
  endfunction

  state_t      state_r, state_nxt_s;
  logic [2:0]  skip_cnt_r, skip_nxt_s;
  logic        dec_vld_s, dec_ext_s, dec_rel_s, dec_make_s;
  logic [7:0]  dec_code_s;
  logic        last_vld_r, last_ext_r;
  logic [7:0]  last_code_r;
  logic        rep_hit_s, push_s;

  logic [9:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_inc_s;
  logic [AW:0] count_r, count_nxt_s;
  logic        pop_s, full_s, wr_ok_s;
  logic [9:0]  head_r, head_nxt_s;
  logic        empty_r, full_r, overflow_r;

  // Sequence parser: next state and the event completed by the current byte.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_cnt_r;
    dec_vld_s   = 1'b0;
    dec_code_s  = byte_in;
    dec_ext_s   = 1'b0;
    dec_rel_s   = 1'b0;
    dec_make_s  = 1'b0;
    if (byte_valid) begin
      case (state_r)
        S_IDLE: begin
          if (byte_in == 8'hE0) begin
            state_nxt_s = S_EXT;
          end else if (byte_in == 8'hF0) begin
            state_nxt_s = S_BRK;
          end else if (byte_in == 8'hE1) begin
            // Pause: report once as extended 77, then swallow the 7 trailing bytes.
            state_nxt_s = S_SKIP;
            skip_nxt_s  = 3'd7;
            dec_vld_s   = 1'b1;
            dec_code_s  = 8'h77;
            dec_ext_s   = 1'b1;
          end else if (is_discard(byte_in)) begin
            state_nxt_s = S_IDLE;
          end else begin
            dec_vld_s  = 1'b1;
            dec_make_s = 1'b1;
          end
        end
        S_EXT: begin
          if (byte_in == 8'hF0) begin
            state_nxt_s = S_EXT_BRK;
          end else if (byte_in == 8'hE0) begin
            state_nxt_s = S_EXT;
          end else if (byte_in == 8'h12) begin
            state_nxt_s = S_IDLE;   // fake shift
          end else begin
            state_nxt_s = S_IDLE;
            dec_vld_s   = 1'b1;
            dec_make_s  = 1'b1;
            dec_ext_s   = 1'b1;
          end
        end
        S_BRK: begin
          state_nxt_s = S_IDLE;
          dec_vld_s   = 1'b1;
          dec_rel_s   = 1'b1;
        end
        S_EXT_BRK: begin
          state_nxt_s = S_IDLE;
          if (byte_in == 8'h12) begin
            dec_vld_s = 1'b0;
          end else begin
            dec_vld_s = 1'b1;
            dec_ext_s = 1'b1;
            dec_rel_s = 1'b1;
          end
        end
        S_SKIP: begin
          skip_nxt_s = skip_cnt_r - 3'd1;
          if (skip_cnt_r <= 3'd1) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_SKIP;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
          skip_nxt_s  = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Repeat filter and FIFO push/pop qualification.
  always_comb begin
    rep_hit_s = SUPPRESS_REPEAT && dec_make_s && last_vld_r &&
                (last_code_r == dec_code_s) && (last_ext_r == dec_ext_s);
    push_s    = dec_vld_s & ~rep_hit_s;
    pop_s     = ev_rd & (count_r != {(AW+1){1'b0}});
    full_s    = (count_r == DEPTH_C);
    wr_ok_s   = push_s & (~full_s | pop_s);
    rd_ptr_inc_s = rd_ptr_r + 1'b1;
  end

  // Next FIFO occupancy and next head entry for the registered outputs.
  always_comb begin
    count_nxt_s = count_r;
    head_nxt_s  = head_r;
    case ({wr_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + 1'b1;
      2'b01:   count_nxt_s = count_r - 1'b1;
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      // After a pop the head is the next stored entry, or the incoming event
      // when the popped entry was the only one.
      if (count_r > {{AW{1'b0}}, 1'b1}) begin
        head_nxt_s = mem_r[rd_ptr_inc_s];
      end else if (wr_ok_s) begin
        head_nxt_s = {dec_code_s, dec_ext_s, dec_rel_s};
      end else begin
        head_nxt_s = head_r;
      end
    end else if (wr_ok_s && (count_r == {(AW+1){1'b0}})) begin
      head_nxt_s = {dec_code_s, dec_ext_s, dec_rel_s};
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Parser state, skip counter and last-make register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      skip_cnt_r  <= 3'd0;
      last_vld_r  <= 1'b0;
      last_code_r <= 8'h00;
      last_ext_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      skip_cnt_r <= skip_nxt_s;
      if (push_s && dec_make_s) begin
        last_vld_r  <= 1'b1;
        last_code_r <= dec_code_s;
        last_ext_r  <= dec_ext_s;
      end else if (dec_vld_s && dec_rel_s) begin
        last_vld_r <= 1'b0;
      end
    end
  end

  // FIFO storage (contents need no reset; occupancy tracks validity).
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= {dec_code_s, dec_ext_s, dec_rel_s};
    end
  end

  // FIFO pointers, occupancy, registered head/status outputs, sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      head_r     <= 10'd0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      count_r <= count_nxt_s;
      head_r  <= head_nxt_s;
      empty_r <= (count_nxt_s == {(AW+1){1'b0}});
      full_r  <= (count_nxt_s == DEPTH_C);
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign ev_code    = head_r[9:2];
  assign ev_ext     = head_r[1];
  assign ev_release = head_r[0];
  assign ev_empty   = empty_r;
  assign ev_full    = full_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 8;

  logic       clk, rst, byte_valid, ev_rd;
  logic [7:0] byte_in;
  logic [7:0] ev_code, ev_code0;
  logic       ev_ext, ev_release, ev_empty, ev_full, overflow;
  logic       ev_ext0, ev_release0, ev_empty0, ev_full0, overflow0, rd0;

  ps2_scancode_decoder #(.DEPTH(DEPTH), .SUPPRESS_REPEAT(1'b1)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .ev_rd(ev_rd),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_release(ev_release),
    .ev_empty(ev_empty), .ev_full(ev_full), .overflow(overflow));

  // Second instance without repeat suppression, drained every cycle.
  ps2_scancode_decoder #(.DEPTH(DEPTH), .SUPPRESS_REPEAT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .ev_rd(rd0),
    .ev_code(ev_code0), .ev_ext(ev_ext0), .ev_release(ev_release0),
    .ev_empty(ev_empty0), .ev_full(ev_full0), .overflow(overflow0));

  assign rd0 = ~ev_empty0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Scoreboards: {code, ext, release}
  logic [9:0] q1[$];
  logic [9:0] q0[$];
  bit exp_ovf = 1'b0;

  // Reference model state: pending prefixes, bytes left to skip, last make.
  bit m_ext = 1'b0, m_brk = 1'b0;
  int m_skip = 0;
  bit lv1 = 1'b0, le1 = 1'b0;
  logic [7:0] lc1 = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit discard(input logic [7:0] b);
    return (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
            b == 8'hFC || b == 8'hFD || b == 8'hFE || b == 8'hFF);
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit rd);
    bit hv = 1'b0, mk = 1'b0, x = 1'b0, r = 1'b0;
    logic [7:0] c = b;
    if (m_skip > 0) begin
      m_skip--;
    end else if (m_brk) begin
      if (!(m_ext && b == 8'h12)) begin hv = 1'b1; x = m_ext; r = 1'b1; end
      m_brk = 1'b0; m_ext = 1'b0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'h12) m_ext = 1'b0;
      else begin hv = 1'b1; mk = 1'b1; x = 1'b1; m_ext = 1'b0; end
    end else begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE1) begin m_skip = 7; hv = 1'b1; c = 8'h77; x = 1'b1; end
      else if (!discard(b)) begin hv = 1'b1; mk = 1'b1; end
    end
    if (hv) begin
      q0.push_back({c, x, r});
      if (!(mk && lv1 && lc1 == c && le1 == x)) begin
        if (q1.size() < DEPTH || (rd && q1.size() > 0)) q1.push_back({c, x, r});
        else exp_ovf = 1'b1;
        if (mk) begin lv1 = 1'b1; lc1 = c; le1 = x; end
      end
      if (r) lv1 = 1'b0;
    end
  endtask

  // One clock edge worth of stimulus, applied at the falling edge.
  task automatic drive(input bit bv, input logic [7:0] b, input bit rd, input bit r);
    @(negedge clk);
    rst = r; byte_valid = bv; byte_in = b; ev_rd = rd;
    if (r) begin
      q1.delete(); q0.delete(); exp_ovf = 1'b0;
      m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; lv1 = 1'b0;
    end else if (bv) begin
      model_byte(b, rd);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit rd);
    drive(1'b1, b, rd, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q1.size() > 0 || q0.size() > 0); i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drain_q1_left", q1.size(), 0);
    chk("drain_q0_left", q0.size(), 0);
  endtask

  // Pop monitor: compares the head whenever a pop is about to happen.
  logic [9:0] e1, e0;
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (ev_rd && !ev_empty) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL ev1_unexpected actual=%0h required=none", {ev_code, ev_ext, ev_release});
        end else begin
          e1 = q1.pop_front();
          chk("ev1_head", {ev_code, ev_ext, ev_release}, e1);
        end
      end
      if (!ev_empty0) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL ev0_unexpected actual=%0h required=none", {ev_code0, ev_ext0, ev_release0});
        end else begin
          e0 = q0.pop_front();
          chk("ev0_head", {ev_code0, ev_ext0, ev_release0}, e0);
        end
      end
    end
  end

  // Status monitor: occupancy flags and overflow just after each edge.
  always @(posedge clk) begin
    #1;
    chk("ev_empty", ev_empty, q1.size() == 0);
    chk("ev_full", ev_full, q1.size() == DEPTH);
    chk("overflow", overflow, exp_ovf);
    chk("ev_empty0", ev_empty0, q0.size() == 0);
    chk("overflow0", overflow0, 0);
  end

  logic [7:0] rtab [16] = '{8'h1C, 8'h1C, 8'h1C, 8'h75, 8'h12, 8'hE0, 8'hE0, 8'hF0,
                            8'hF0, 8'hAA, 8'hFA, 8'h00, 8'h7C, 8'h23, 8'h5A, 8'hFE};
  logic [7:0] fill [10] = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h44, 8'h43};

  initial begin
    rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; ev_rd = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst_code", ev_code, 0);
    chk("rst_ext", ev_ext, 0);
    chk("rst_release", ev_release, 0);

    // Make/break, extended keys, Print Screen fake shift
    send(8'h1C, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    drain();
    send(8'hE0, 1'b0); send(8'h75, 1'b0); send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    send(8'hE0, 1'b0); send(8'h12, 1'b0); send(8'hE0, 1'b0); send(8'h7C, 1'b0);
    drain();
    // Typematic repeat
    send(8'h1C, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
    drain();
    // Pause, then status bytes
    send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
    send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0); send(8'h77, 1'b0);
    send(8'h1C, 1'b0); send(8'hAA, 1'b0); send(8'hFA, 1'b0);
    drain();

    // Fill to full, push+pop while full, then overflow
    for (int i = 0; i < 8; i++) send(fill[i], 1'b0);
    @(posedge clk); #1;
    chk("full_after_8", ev_full, 1);
    chk("no_ovf_at_8", overflow, 0);
    send(fill[8], 1'b1);
    @(posedge clk); #1;
    chk("full_after_pushpop", ev_full, 1);
    chk("no_ovf_pushpop", overflow, 0);
    send(fill[9], 1'b0);
    @(posedge clk); #1;
    chk("ovf_after_9th", overflow, 1);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("empty_after_8_pops", ev_empty, 1);

    // Reset in the middle of an extended break
    send(8'hE0, 1'b0); send(8'hF0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst_mid_empty", ev_empty, 1);
    chk("rst_mid_ovf", overflow, 0);
    chk("rst_mid_code", ev_code, 0);
    send(8'h75, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("after_rst_75", {ev_code, ev_ext, ev_release}, {8'h75, 1'b0, 1'b0});
    drain();

    // Randomized traffic
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(9, 0) < 7, rtab[$urandom_range(15, 0)], $urandom_range(9, 0) < 4, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes the raw PS/2 Set-2 byte stream from the keyboard receiver stage. Bytes arrive as 8-bit values with a one-cycle strobe in the system clock domain.
- Assembles multi-byte sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence) into single key events.
- Optionally suppresses typematic auto-repeat.
- Buffers events in a small first-word-fall-through (FWFT) FIFO for the downstream consumer (display/control logic).

Parameters:
- DEPTH, 8, event FIFO depth in entries; power of two, 2..64.
- SUPPRESS_REPEAT, 1, 1 = drop a make event identical to the last accepted make while no break has intervened.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- byte_in  in  8  received scan-code byte; valid only when byte_valid=1
- byte_valid  in  1  one-cycle strobe, at most one per cycle
- ev_rd  in  1  pop head event; ignored when ev_empty=1
- ev_code  out  8  head event scan code
- ev_ext  out  1  head event came from an E0-prefixed sequence (or Pause)
- ev_release  out  1  head event is a break (key up)
- ev_empty  out  1  FIFO empty
- ev_full  out  1  FIFO full
- overflow  out  1  sticky; an event was lost because the FIFO was full

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, FIFO emptied, ev_empty=1, ev_full=0, overflow=0, ev_code/ev_ext/ev_release=0, last-make register invalid, skip counter=0. Reset mid-sequence discards the partial sequence.
- FSM advances only on byte_valid=1. States: IDLE, EXT, BRK, EXT_BRK, SKIP.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP with skip counter=7; emit event {code=77, ext=1, release=0}.
  - 00, AA, EE, FA, FC, FD, FE, FF -> discarded, stay IDLE.
  - Any other byte -> emit make {byte, ext=0}.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - 12 (fake shift) -> IDLE, no event.
  - Other -> emit make {byte, ext=1}, go to IDLE.
- BRK: any byte -> emit break {byte, ext=0}, go to IDLE.
- EXT_BRK:
  - 12 -> IDLE, no event.
  - Other -> emit break {byte, ext=1}, go to IDLE.
- SKIP: each byte decrements the counter; at 0 -> IDLE. No events are emitted from SKIP.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - A make equal in {code, ext} to the valid last-make register is dropped.
  - An accepted make loads the register.
  - Any break invalidates it.
  - With SUPPRESS_REPEAT=0, every make is emitted.
- Latency: an event completed by the byte with byte_valid at edge N is visible at the outputs after edge N (ev_empty falls, ev_* valid) when the FIFO was empty. This is a one-edge registered latency.
- FIFO: FWFT; ev_code/ev_ext/ev_release always reflect the head entry.
  - ev_rd=1 with ev_empty=0 pops at the edge.
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Simultaneous push+pop leaves the count unchanged.
  - Push when full without a pop: event dropped, overflow<=1, held until rst.
  - Pointers wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits.
  - ev_full=1 iff count==DEPTH; ev_empty=1 iff count==0.
  - Outputs hold their last head value while empty; consumers must not read them then.
- Parse state and FIFO are independent: a full FIFO never stalls or corrupts parsing.

Test Plan:
- After rst, bytes 1C, F0, 1C -> events {1C,0,0} then {1C,0,1}; ev_empty falls one edge after the 1C strobe.
- E0 75, E0 F0 75 (Up arrow) -> {75,1,0}, {75,1,1}. Print Screen make E0 12 E0 7C -> single event {7C,1,0}.
- SUPPRESS_REPEAT=1; bytes 1C,1C,1C,F0,1C,1C -> events {1C,0,0},{1C,0,1},{1C,0,0}. With SUPPRESS_REPEAT=0 -> five events.
- Pause sequence E1 14 77 E1 F0 14 F0 77, followed by 1C -> exactly {77,1,0} then {1C,0,0}. Bytes AA and FA in IDLE -> no events.
- DEPTH=8, no ev_rd, 9 make events -> ev_full=1 after the 8th, overflow=1 after the 9th. Popping 8 times returns the first 8 events in order, then ev_empty=1. Push and pop in the same cycle while full -> count stays 8, no overflow.
- Assert rst after E0 F0 -> FIFO empty, overflow=0. Then byte 75 -> {75,0,0}, not an extended break.
